// File: rtl/hdc_fetch_pkg.sv
// Shared types for the item-memory stream fetchers: FSM state encoding and start-time config.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hdc_fetch_pkg;

    localparam int unsigned FetchAddrWidth = 32;
    localparam int unsigned FetchLenWidth  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    // Job description captured when a start pulse is accepted.
    typedef struct packed {
        logic [FetchAddrWidth-1:0] base;
        logic [FetchAddrWidth-1:0] stride;
        logic [FetchLenWidth-1:0]  num_items;
    } fetch_cfg_t;

endpackage

// File: rtl/fifo.sv
// Generic FIFO with optional fall-through (empty FIFO forwards a push to the output in the same cycle).
// Latency: 1 cycle push-to-pop, 0 cycles when FallThrough=1 and the FIFO is empty.
// Backpressure: full_o / empty_o; caller must not push when full or pop when empty.
module fifo #(
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned DataWidth   = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clr_i,
    input  logic                               push_i,
    input  logic [DataWidth-1:0]               data_i,
    input  logic                               pop_i,
    output logic [DataWidth-1:0]               data_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [$clog2(FifoDepth+1)-1:0]     usage_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    logic [DataWidth-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 bypass;
    logic                 wr;
    logic                 rd;

    // A push straight into a pop on an empty fall-through FIFO never touches storage.
    assign bypass  = FallThrough && (count_q == '0) && push_i && pop_i;
    assign wr      = push_i && !bypass;
    assign rd      = pop_i && !bypass && (count_q != '0);
    assign full_o  = (count_q == CntW'(FifoDepth));
    assign empty_o = (count_q == '0) && !(FallThrough && push_i);
    assign data_o  = (FallThrough && (count_q == '0)) ? data_i : mem_q[rd_ptr_q];
    assign usage_o = count_q;

    // Pointer and occupancy bookkeeping; clear flushes the contents.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (rd) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(wr) - CntW'(rd);
        end
    end

    // Storage array, no reset needed: contents are only read when occupancy says so.
    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni || clr_i) !(push_i && full_o));

endmodule

// File: rtl/im_stream_fetcher.sv
// Strided memory fetcher feeding the item memory lowdim port; optional stall counter under IM_FETCH_PERF_EN.
// Latency: response to lowdim output is 0 cycles (fall-through buffer) when the buffer is empty.
// Backpressure: requests are credit-limited so inflight + buffered never exceeds BufDepth; output is valid/ready.
module im_stream_fetcher
    import hdc_fetch_pkg::*;
#(
    parameter int unsigned ImAddrWidth  = 32,
    parameter int unsigned MemAddrWidth = 32,
    parameter int unsigned LenWidth     = 16,
    parameter int unsigned BufDepth     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    start_i,
    input  logic [MemAddrWidth-1:0] base_addr_i,
    input  logic [MemAddrWidth-1:0] stride_i,
    input  logic [LenWidth-1:0]     num_items_i,
    output logic                    busy_o,
    output logic                    done_o,
`ifdef IM_FETCH_PERF_EN
    output logic [31:0]             stall_cycles_o,
`endif
    output logic                    mem_req_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [ImAddrWidth-1:0]  mem_rdata_i,
    output logic [ImAddrWidth-1:0]  lowdim_data_o,
    output logic                    data_valid_o,
    input  logic                    data_ready_i
);

    localparam int unsigned CntW = $clog2(BufDepth + 1);

    fetch_state_e            state_q, state_d;
    fetch_cfg_t              cfg_in;
    logic [MemAddrWidth-1:0] addr_q;
    logic [MemAddrWidth-1:0] stride_q;
    logic [LenWidth-1:0]     num_q;
    logic [LenWidth-1:0]     issued_q;
    logic [LenWidth-1:0]     delivered_q;
    logic [CntW-1:0]         inflight_q;
    logic [CntW-1:0]         discard_q;
    logic [CntW-1:0]         buf_count;
    logic [ImAddrWidth-1:0]  buf_data;
    logic                    buf_empty;
    logic                    buf_full;
    logic                    start_ok;
    logic                    req;
    logic                    gnt;
    logic                    drop;
    logic                    push;
    logic                    pop;
    logic                    last_grant;
    logic                    last_pop;

    assign cfg_in = '{base:      FetchAddrWidth'(base_addr_i),
                      stride:    FetchAddrWidth'(stride_i),
                      num_items: FetchLenWidth'(num_items_i)};

    // Starts wait until every response of an aborted run has been swallowed.
    assign start_ok   = (state_q == IDLE) && start_i && (discard_q == '0) && !clr_i;
    assign req        = (state_q == FETCH) && !clr_i &&
                        (({1'b0, inflight_q} + {1'b0, buf_count}) < (CntW+1)'(BufDepth));
    assign gnt        = req && mem_gnt_i;
    assign drop       = mem_rvalid_i && (discard_q != '0);
    assign push       = mem_rvalid_i && !drop && !clr_i;
    assign data_valid_o = !buf_empty && !clr_i;
    assign pop        = data_valid_o && data_ready_i;
    assign last_grant = gnt && (issued_q == num_q - LenWidth'(1));
    assign last_pop   = pop && (delivered_q == num_q - LenWidth'(1));

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign mem_req_o     = req;
    assign mem_addr_o    = addr_q;
    assign lowdim_data_o = data_valid_o ? buf_data : '0;

    fifo #(
        .FallThrough (1'b1),
        .FifoDepth   (BufDepth),
        .DataWidth   (ImAddrWidth)
    ) u_rsp_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (push),
        .data_i  (mem_rdata_i),
        .pop_i   (pop),
        .data_o  (buf_data),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .usage_o (buf_count)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything and suppresses the done pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = (num_items_i == '0) ? DONE : FETCH;
            FETCH:   if (last_grant) state_d = DRAIN;
            DRAIN:   if (last_pop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
        end
    end

    // Address walk, issue/delivery counters and response accounting.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            stride_q    <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= '0;
            discard_q   <= '0;
        end else if (clr_i) begin
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= '0;
            // Outstanding responses (minus one landing right now) must be dropped later.
            discard_q   <= CntW'({1'b0, discard_q} + {1'b0, inflight_q} - (CntW+1)'(mem_rvalid_i));
        end else begin
            if (start_ok) begin
                addr_q      <= MemAddrWidth'(cfg_in.base);
                stride_q    <= MemAddrWidth'(cfg_in.stride);
                num_q       <= LenWidth'(cfg_in.num_items);
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (gnt) begin
                    addr_q   <= addr_q + stride_q;
                    issued_q <= issued_q + LenWidth'(1);
                end
                if (pop) begin
                    delivered_q <= delivered_q + LenWidth'(1);
                end
            end
            inflight_q <= inflight_q + CntW'(gnt) - CntW'(push);
            if (drop) begin
                discard_q <= discard_q - CntW'(1);
            end
        end
    end

    push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && buf_full));

`ifdef IM_FETCH_PERF_EN
    logic [31:0] stall_q;
    logic [1:0]  stall_inc;
    logic [32:0] stall_sum;

    assign stall_inc      = {1'b0, data_valid_o & ~data_ready_i} + {1'b0, req & ~mem_gnt_i};
    assign stall_sum      = {1'b0, stall_q} + 33'(stall_inc);
    assign stall_cycles_o = stall_q;

    // Saturating stall counter covering downstream and memory-side stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i || start_ok) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_im_stream_fetcher.sv
// Directed bench for im_stream_fetcher with a fixed-latency memory model.
// Latency: model returns responses lat cycles after grant.
// Backpressure: data_ready_i and mem_gnt_i driven per scenario.
module tb_im_stream_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic [15:0] num = '0;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] lowdim;
    logic        dvalid;
    logic        ready = 1'b1;
`ifdef IM_FETCH_PERF_EN
    logic [31:0] stall;
    logic [31:0] stall_at_done = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int          lat = 1;
    int          ncyc = 0;
    logic [7:0]  tag = 8'h00;
    int          rsp_due[$];
    logic [31:0] rsp_dat[$];
    logic [31:0] gnt_log[$];
    logic [31:0] got_log[$];
    int          done_cnt = 0;
    int          unstable = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data = '0;

    always #5 clk = ~clk;

    im_stream_fetcher dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr),
        .start_i        (start),
        .base_addr_i    (base_addr),
        .stride_i       (stride),
        .num_items_i    (num),
        .busy_o         (busy),
        .done_o         (done),
`ifdef IM_FETCH_PERF_EN
        .stall_cycles_o (stall),
`endif
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_gnt_i      (gnt),
        .mem_rvalid_i   (rvalid),
        .mem_rdata_i    (rdata),
        .lowdim_data_o  (lowdim),
        .data_valid_o   (dvalid),
        .data_ready_i   (ready)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a, input logic [7:0] t);
        return {t, 24'h0} ^ a ^ 32'h5A00_00C3;
    endfunction

    // Mid-cycle monitor: grants feed the memory model, handshakes and done pulses are logged.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && gnt) begin
                gnt_log.push_back(mem_addr);
                rsp_due.push_back(ncyc + lat);
                rsp_dat.push_back(data_of(mem_addr, tag));
            end
            if (dvalid && ready) got_log.push_back(lowdim);
            if (done) begin
                done_cnt++;
`ifdef IM_FETCH_PERF_EN
                stall_at_done = stall;
`endif
            end
            if (hold_prev && (!dvalid || lowdim != prev_data)) unstable++;
            hold_prev = dvalid && !ready;
            prev_data = lowdim;
        end
    end

    // Memory response driver: in-order responses, each due lat cycles after its grant.
    always @(posedge clk) begin
        #1;
        ncyc++;
        if (rsp_due.size() != 0 && rsp_due[0] <= ncyc) begin
            rvalid = 1'b1;
            rdata  = rsp_dat.pop_front();
            void'(rsp_due.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        got_log.delete();
        unstable = 0;
    endtask

    task automatic start_run(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n);
        base_addr = b;
        stride    = s;
        num       = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) seen = 1'b1;
        end
        tick();
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: done_o not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        ready = 1'b1;
        gnt   = 1'b1;
        repeat (3) tick();
        rsp_due.delete();
        rsp_dat.delete();
        n_cmp++; if ({busy, done, mem_req, dvalid} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, mem_req, dvalid}); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (lowdim !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", lowdim); end
`ifdef IM_FETCH_PERF_EN
        n_cmp++; if (stall !== 32'h0) begin n_bad++; $display("FAIL reset_stall: got %0d expected 0", stall); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int d0;
        lat = 1; ready = 1'b1; gnt = 1'b1; tag = 8'h01;
        clear_logs();
        d0 = done_cnt;
        start_run(32'h100, 32'h4, 16'd3);
        wait_done(50, "basic_done");
        repeat (3) tick();
        n_cmp++; if (gnt_log.size() !== 3) begin n_bad++; $display("FAIL basic_ngrants: got %0d expected 3", gnt_log.size()); end
        n_cmp++; if (gnt_log[0] !== 32'h100) begin n_bad++; $display("FAIL basic_addr0: got %h expected 100", gnt_log[0]); end
        n_cmp++; if (gnt_log[1] !== 32'h104) begin n_bad++; $display("FAIL basic_addr1: got %h expected 104", gnt_log[1]); end
        n_cmp++; if (gnt_log[2] !== 32'h108) begin n_bad++; $display("FAIL basic_addr2: got %h expected 108", gnt_log[2]); end
        n_cmp++; if (got_log.size() !== 3) begin n_bad++; $display("FAIL basic_nwords: got %0d expected 3", got_log.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got_log[i] !== data_of(32'h100 + 32'(4 * i), 8'h01)) begin
                n_bad++;
                $display("FAIL basic_word%0d: got %h expected %h", i, got_log[i], data_of(32'h100 + 32'(4 * i), 8'h01));
            end
        end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_done_once: got %0d expected 1", done_cnt - d0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_zero_items();
        clear_logs();
        start_run(32'h500, 32'h4, 16'd0);
        n_cmp++; if ({busy, done} !== 2'b11) begin n_bad++; $display("FAIL zero_pulse: got busy,done=%b expected 11", {busy, done}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL zero_after: got busy,done=%b expected 00", {busy, done}); end
        n_cmp++; if (gnt_log.size() !== 0) begin n_bad++; $display("FAIL zero_noreq: got %0d grants expected 0", gnt_log.size()); end
    endtask

    task automatic test_backpressure();
        lat = 1; ready = 1'b0; gnt = 1'b1; tag = 8'h03;
        clear_logs();
        start_run(32'h200, 32'h10, 16'd5);
        repeat (20) tick();
        n_cmp++; if (gnt_log.size() !== 2) begin n_bad++; $display("FAIL bp_grants_stalled: got %0d expected 2", gnt_log.size()); end
        n_cmp++; if (dvalid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", dvalid); end
        check32("bp_head_word", lowdim, data_of(32'h200, 8'h03));
        n_cmp++; if (got_log.size() !== 0) begin n_bad++; $display("FAIL bp_no_accept: got %0d expected 0", got_log.size()); end
        ready = 1'b1;
        wait_done(80, "bp_done");
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        n_cmp++; if (got_log.size() !== 5) begin n_bad++; $display("FAIL bp_nwords: got %0d expected 5", got_log.size()); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (got_log[i] !== data_of(32'h200 + 32'(16 * i), 8'h03)) begin
                n_bad++;
                $display("FAIL bp_word%0d: got %h expected %h", i, got_log[i], data_of(32'h200 + 32'(16 * i), 8'h03));
            end
        end
        check32("bp_last_addr", gnt_log[4], 32'h240);
    endtask

    task automatic test_addr_wrap();
        lat = 1; ready = 1'b1; gnt = 1'b1; tag = 8'h04;
        clear_logs();
        start_run(32'hFFFF_FFFC, 32'h8, 16'd2);
        wait_done(40, "wrap_done");
        check32("wrap_addr0", gnt_log[0], 32'hFFFF_FFFC);
        check32("wrap_addr1", gnt_log[1], 32'h0000_0004);
        check32("wrap_word1", got_log[1], data_of(32'h0000_0004, 8'h04));
    endtask

    task automatic test_clear();
        int d0;
        lat = 3; ready = 1'b1; gnt = 1'b1; tag = 8'h11;
        clear_logs();
        d0 = done_cnt;
        start_run(32'h300, 32'h4, 16'd4);
        tick();
        tick();
        n_cmp++; if (gnt_log.size() !== 2) begin n_bad++; $display("FAIL clr_inflight: got %0d grants expected 2", gnt_log.size()); end
        clr = 1'b1;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL clr_req_drop: got %b expected 0", mem_req); end
        tick();
        clr = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_idle: got %b expected 0", busy); end
        clear_logs();
        tag       = 8'h22;
        base_addr = 32'h400;
        stride    = 32'h4;
        num       = 16'd2;
        start     = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_hold1: got busy %b expected 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_hold2: got busy %b expected 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_accept: got busy %b expected 1", busy); end
        start = 1'b0;
        wait_done(60, "clr_done");
        n_cmp++; if (got_log.size() !== 2) begin n_bad++; $display("FAIL clr_nwords: got %0d expected 2", got_log.size()); end
        check32("clr_word0", got_log[0], data_of(32'h400, 8'h22));
        check32("clr_word1", got_log[1], data_of(32'h404, 8'h22));
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL clr_no_pulse: got %0d pulses expected 1", done_cnt - d0); end
    endtask

`ifdef IM_FETCH_PERF_EN
    task automatic test_perf();
        bit seen;
        lat = 1; ready = 1'b0; gnt = 1'b1; tag = 8'h06;
        clear_logs();
        start_run(32'h600, 32'h4, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (dvalid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL perf_valid: got %b expected 1", seen); end
        repeat (7) @(posedge clk);
        #2;
        ready = 1'b1;
        wait_done(40, "perf_done");
        check32("perf_stall", stall_at_done, 32'd7);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_items();
        test_backpressure();
        test_addr_wrap();
        test_clear();
`ifdef IM_FETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
